// File: rtl/seq_multiplier_param.sv
// Sequential add-shift multiplier over an X:A:B register chain, signed or unsigned.
// One add/subtract and one shift per multiplier bit; Busy/Done handshake on a Run press.
module seq_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic                 Run,
  input  logic                 Signed_Mode,
  input  logic [WIDTH-1:0]     Din,
  output logic [WIDTH-1:0]     Aval,
  output logic [WIDTH-1:0]     Bval,
  output logic                 Xval,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADD   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_s;
  logic [WIDTH:0]   addend_s;
  logic [WIDTH:0]   sum_s;

  function automatic logic [WIDTH:0] ext_op(input logic [WIDTH-1:0] v, input logic sgn);
    return sgn ? {v[WIDTH-1], v} : {1'b0, v};
  endfunction

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    start_s  = Run & ~run_q;
    addend_s = b_q[0] ? ext_op(s_q, mode_q) : {(WIDTH+1){1'b0}};
    // The last multiplier bit carries negative weight in two's complement.
    if (mode_q && (cnt_q == LAST)) begin
      sum_s = {x_q, a_q} - addend_s;
    end else begin
      sum_s = {x_q, a_q} + addend_s;
    end

    case (state_q)
      S_IDLE: begin
        if (Load) begin
          b_d = Din;
          x_d = 1'b0;
          a_d = {WIDTH{1'b0}};
        end else if (start_s) begin
          s_d     = Din;
          mode_d  = Signed_Mode;
          x_d     = 1'b0;
          a_d     = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        {x_d, a_d} = sum_s;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        a_d = {x_q, a_q[WIDTH-1:1]};
        b_d = {a_q[0], b_q[WIDTH-1:1]};
        x_d = mode_q ? x_q : 1'b0;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = Run ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        state_d = Run ? S_HOLD : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ADD) || (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      x_q     <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      mode_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      run_q   <= Run;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Aval    = a_q;
  assign Bval    = b_q;
  assign Xval    = x_q;
  assign Product = {a_q, b_q};
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Drives WIDTH=8, 4 and 12 multipliers in lockstep and checks them against an
// arithmetic reference product, with directed corner cases and random operands.
module tb_seq_multiplier_param;

  logic        Clk;
  logic        Reset;
  logic        Load;
  logic        Run;
  logic        Signed_Mode;
  logic [7:0]  din8;
  logic [3:0]  din4;
  logic [11:0] din12;

  logic [7:0]  a8, bv8;
  logic        x8, busy8, done8;
  logic [15:0] p8;
  logic [3:0]  a4, bv4;
  logic        x4, busy4, done4;
  logic [7:0]  p4;
  logic [11:0] a12, bv12;
  logic        x12, busy12, done12;
  logic [23:0] p12;

  logic [7:0]  b8_m;
  logic [3:0]  b4_m;
  logic [11:0] b12_m;

  int vectors;
  int miscompares;

  seq_multiplier_param #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Run(Run), .Signed_Mode(Signed_Mode),
    .Din(din8), .Aval(a8), .Bval(bv8), .Xval(x8), .Product(p8), .Busy(busy8), .Done(done8)
  );

  seq_multiplier_param #(.WIDTH(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Run(Run), .Signed_Mode(Signed_Mode),
    .Din(din4), .Aval(a4), .Bval(bv4), .Xval(x4), .Product(p4), .Busy(busy4), .Done(done4)
  );

  seq_multiplier_param #(.WIDTH(12)) dut12 (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Run(Run), .Signed_Mode(Signed_Mode),
    .Din(din12), .Aval(a12), .Bval(bv12), .Xval(x12), .Product(p12), .Busy(busy12), .Done(done12)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full-width product of two w-bit operands, as plain integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic [63:0] b, input logic [63:0] s,
                                          input int w, input logic mode);
    longint bb, ss, p, one;
    one = 64'sd1;
    bb  = longint'(b);
    ss  = longint'(s);
    if (mode) begin
      if (b[w-1]) bb = bb - (one << w);
      if (s[w-1]) ss = ss - (one << w);
    end
    p = bb * ss;
    return 64'(p) & 64'((one << (2 * w)) - one);
  endfunction

  task automatic do_load(input logic [7:0] b8, input logic [3:0] b4, input logic [11:0] b12);
    Load = 1'b1; din8 = b8; din4 = b4; din12 = b12;
    @(negedge Clk);
    Load = 1'b0;
    @(negedge Clk);
    chk("ld_b8", 64'(bv8), 64'(b8));
    chk("ld_a8", 64'(a8), 64'd0);
    chk("ld_b4", 64'(bv4), 64'(b4));
    chk("ld_b12", 64'(bv12), 64'(b12));
    b8_m = b8; b4_m = b4; b12_m = b12;
  endtask

  task automatic run_op(input logic [7:0] s8, input logic [3:0] s4, input logic [11:0] s12,
                        input logic mode, input int hold, input bit disturb);
    logic [63:0] e8, e4, e12;
    e8  = ref_mul(64'(b8_m), 64'(s8), 8, mode);
    e4  = ref_mul(64'(b4_m), 64'(s4), 4, mode);
    e12 = ref_mul(64'(b12_m), 64'(s12), 12, mode);
    din8 = s8; din4 = s4; din12 = s12; Signed_Mode = mode; Load = 1'b0; Run = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge Clk);
      chk("busy8", 64'(busy8), 64'(n <= 16));
      chk("done8", 64'(done8), 64'(n == 17));
      chk("busy4", 64'(busy4), 64'(n <= 8));
      chk("done4", 64'(done4), 64'(n == 9));
      chk("busy12", 64'(busy12), 64'(n <= 24));
      chk("done12", 64'(done12), 64'(n == 25));
      if (n == 17) begin
        chk("prod8", 64'(p8), e8);
        chk("x8", 64'(x8), 64'(mode & e8[15]));
      end
      if (n == 9) begin
        chk("prod4", 64'(p4), e4);
        chk("x4", 64'(x4), 64'(mode & e4[7]));
      end
      if (n == 25) begin
        chk("prod12", 64'(p12), e12);
        chk("x12", 64'(x12), 64'(mode & e12[23]));
      end
      if (n == hold) Run = 1'b0;
      if (disturb && n >= 2 && n <= 6) begin
        Run = n[0];
        Load = ~n[0];
        Signed_Mode = ~Signed_Mode;
        din8 = 8'($urandom); din4 = 4'($urandom); din12 = 12'($urandom);
      end
      if (disturb && n == 7) begin
        Run = 1'b0;
        Load = 1'b0;
      end
    end
    chk("stable8", 64'(p8), e8);
    chk("stable12", 64'(p12), e12);
    Run = 1'b0; Load = 1'b0;
    @(negedge Clk);
    b8_m = e8[7:0]; b4_m = e4[3:0]; b12_m = e12[11:0];
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    Reset = 1'b1; Load = 1'b0; Run = 1'b0; Signed_Mode = 1'b0;
    din8 = 8'h00; din4 = 4'h0; din12 = 12'h000;
    b8_m = 8'h00; b4_m = 4'h0; b12_m = 12'h000;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_prod8", 64'(p8), 64'd0);
    chk("rst_x8", 64'(x8), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);

    // Unsigned 0xFF x 0xFF
    do_load(8'hFF, 4'hF, 12'hFFF);
    run_op(8'hFF, 4'hF, 12'hFFF, 1'b0, 1, 1'b0);
    chk("ff_ff_u", 64'(p8), 64'h0000_0000_0000_FE01);

    // Signed -59 x 7, then Run held past Done, then chained x2
    do_load(8'hC5, 4'hB, 12'hC55);
    run_op(8'h07, 4'h7, 12'h007, 1'b1, 1, 1'b0);
    chk("c5_07_s", 64'(p8), 64'h0000_0000_0000_FE63);
    chk("c5_07_x", 64'(x8), 64'd1);
    run_op(8'h02, 4'h2, 12'h002, 1'b1, 30, 1'b0);
    chk("chain", 64'(p8), 64'h0000_0000_0000_00C6);

    // Signed corners
    do_load(8'h80, 4'h8, 12'h800);
    run_op(8'h80, 4'h8, 12'h800, 1'b1, 1, 1'b0);
    chk("80_80_s", 64'(p8), 64'h0000_0000_0000_4000);
    do_load(8'hFF, 4'hF, 12'hFFF);
    run_op(8'hFF, 4'hF, 12'hFFF, 1'b1, 1, 1'b0);
    chk("ff_ff_s", 64'(p8), 64'h0000_0000_0000_0001);

    // Load wins over a simultaneous start; the consumed edge does not start later
    Load = 1'b1; Run = 1'b1; din8 = 8'h3C; din4 = 4'h3; din12 = 12'h3C3;
    @(negedge Clk);
    Load = 1'b0;
    @(negedge Clk);
    chk("ldpri_busy", 64'(busy8), 64'd0);
    chk("ldpri_b", 64'(bv8), 64'h3C);
    @(negedge Clk);
    chk("ldpri_busy2", 64'(busy8), 64'd0);
    Run = 1'b0;
    @(negedge Clk);
    b8_m = 8'h3C; b4_m = 4'h3; b12_m = 12'h3C3;

    // Inputs toggled while busy must not disturb the result
    run_op(8'hA7, 4'h9, 12'hA7B, 1'b1, 1, 1'b1);
    run_op(8'h5D, 4'h6, 12'hF0E, 1'b0, 1, 1'b1);

    // Reset in cycle 5 of a run
    do_load(8'h5A, 4'h5, 12'h5A5);
    Run = 1'b1; din8 = 8'h77; din4 = 4'h7; din12 = 12'h777; Signed_Mode = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge Clk);
      if (n == 1) Run = 1'b0;
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("mrst_prod8", 64'(p8), 64'd0);
    chk("mrst_x8", 64'(x8), 64'd0);
    chk("mrst_busy8", 64'(busy8), 64'd0);
    chk("mrst_done8", 64'(done8), 64'd0);
    chk("mrst_prod4", 64'(p4), 64'd0);
    chk("mrst_prod12", 64'(p12), 64'd0);
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      chk("mrst_nodone8", 64'(done8), 64'd0);
      chk("mrst_idle8", 64'(busy8), 64'd0);
    end
    b8_m = 8'h00; b4_m = 4'h0; b12_m = 12'h000;

    // Random operands, modes, Run hold lengths, occasional chaining
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        do_load(8'($urandom), 4'($urandom), 12'($urandom));
      end
      run_op(8'($urandom), 4'($urandom), 12'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(1, 3)), (i % 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
